// File: rtl/dl_cmd_parser_pkg.sv
// dl_cmd_pkg: shared state encoding, sync defaults and byte type for the download command parser
package dl_cmd_pkg;
    localparam int BYTE_W = 8;
    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [2:0] state_t;
    localparam state_t ST_HUNT   = 3'd0;
    localparam state_t ST_SYNC   = 3'd1;
    localparam state_t ST_ADDR   = 3'd2;
    localparam state_t ST_LEN    = 3'd3;
    localparam state_t ST_DATA   = 3'd4;
    localparam state_t ST_CSUM   = 3'd5;
    localparam state_t ST_COMMIT = 3'd6;
    localparam byte_t SYNC0_DEF = 8'hA5;
    localparam byte_t SYNC1_DEF = 8'h5A;
endpackage

// File: rtl/dl_cmd_parser_if.sv
// dl_cmd_parser_if: download-FIFO read port plus cfg register write bus
interface dl_cmd_parser_if;
    logic       dl_fifo_rdreq;
    logic [7:0] dl_fifo_rddata;
    logic       dl_fifo_rdempty;
    logic       cfg_wr_en;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       cfg_ready;
    modport master (
        output dl_fifo_rdreq,
        input  dl_fifo_rddata,
        input  dl_fifo_rdempty,
        output cfg_wr_en,
        output cfg_addr,
        output cfg_wdata,
        input  cfg_ready
    );
    modport slave (
        input  dl_fifo_rdreq,
        output dl_fifo_rddata,
        output dl_fifo_rdempty,
        input  cfg_wr_en,
        input  cfg_addr,
        input  cfg_wdata,
        output cfg_ready
    );
endinterface

// File: rtl/dl_cmd_parser_fetch.sv
// dl_byte_fetch: single-outstanding reader for a normal-mode FIFO (q valid the cycle after rdreq)
module dl_byte_fetch
    import dl_cmd_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  need_i,
    input  logic  rdempty_i,
    input  byte_t rddata_i,
    output logic  rdreq_o,
    output byte_t data_o,
    output logic  vld_o
);
    logic pend_q;
    assign rdreq_o = need_i && !rdempty_i && !pend_q && !rst;
    assign vld_o   = pend_q;
    assign data_o  = rddata_i;
    always_ff @(posedge clk) begin
        pend_q <= rst ? 1'b0 : rdreq_o;
    end
endmodule

// File: rtl/dl_cmd_parser.sv
// dl_cmd_parser: validates A5 5A ADDR LEN PAYLOAD CSUM frames from the download FIFO
// and commits each good frame as auto-incrementing byte writes on the cfg bus.
module dl_cmd_parser
    import dl_cmd_pkg::*;
#(
    parameter int    MAX_LEN = 16,
    parameter int    TIMEOUT = 1024,
    parameter byte_t SYNC0   = SYNC0_DEF,
    parameter byte_t SYNC1   = SYNC1_DEF
) (
    input  logic            clk,
    input  logic            rst,
    dl_cmd_parser_if.master bus,
    output logic            frame_ok_o,
    output logic            frame_err_o,
    output byte_t           err_cnt_o,
    output logic            busy_o
);
    localparam int    IW    = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    localparam int    TW    = $clog2(TIMEOUT + 1);
    localparam byte_t MAX_B = byte_t'(MAX_LEN);

    state_t        st_q, st_d;
    byte_t         addr_q, addr_d, len_q, len_d, csum_q, csum_d;
    byte_t         cfg_addr_q, cfg_addr_d, wdata_q, wdata_d, err_cnt_q;
    logic [IW-1:0] idx_q, idx_d;
    logic [TW-1:0] tmo_q;
    logic          wr_en_q, wr_en_d, ok_q, ok_d, err_q, err_d;
    byte_t         pay_q [MAX_LEN];
    byte_t         rx;
    logic          rx_vld, need, in_frame, tmo_fire, last;

    // Gating need on tmo_fire guarantees nothing is in flight when a frame is abandoned.
    assign in_frame = st_q != ST_HUNT && st_q != ST_COMMIT;
    assign tmo_fire = in_frame && !rx_vld && tmo_q == TW'(TIMEOUT - 1);
    assign need     = st_q != ST_COMMIT && !tmo_fire;
    assign last     = byte_t'(idx_q) == len_q - 8'd1;

    dl_byte_fetch u_fetch (
        .clk       (clk),
        .rst       (rst),
        .need_i    (need),
        .rdempty_i (bus.dl_fifo_rdempty),
        .rddata_i  (bus.dl_fifo_rddata),
        .rdreq_o   (bus.dl_fifo_rdreq),
        .data_o    (rx),
        .vld_o     (rx_vld)
    );

    always_comb begin
        st_d       = st_q;
        addr_d     = addr_q;
        len_d      = len_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        wr_en_d    = wr_en_q;
        cfg_addr_d = cfg_addr_q;
        wdata_d    = wdata_q;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        if (tmo_fire) begin
            st_d  = ST_HUNT;
            err_d = 1'b1;
        end else if (rx_vld) begin
            case (st_q)
                ST_HUNT: st_d = rx == SYNC0 ? ST_SYNC : ST_HUNT;
                ST_SYNC: st_d = rx == SYNC1 ? ST_ADDR : rx == SYNC0 ? ST_SYNC : ST_HUNT;
                ST_ADDR: begin
                    addr_d = rx;
                    csum_d = rx;
                    st_d   = ST_LEN;
                end
                ST_LEN: begin
                    err_d  = rx == 8'd0 || rx > MAX_B;
                    st_d   = err_d ? ST_HUNT : ST_DATA;
                    len_d  = rx;
                    idx_d  = '0;
                    csum_d = csum_q ^ rx;
                end
                ST_DATA: begin
                    csum_d = csum_q ^ rx;
                    idx_d  = last ? idx_q : idx_q + 1'b1;
                    st_d   = last ? ST_CSUM : ST_DATA;
                end
                ST_CSUM: begin
                    err_d      = rx != csum_q;
                    st_d       = err_d ? ST_HUNT : ST_COMMIT;
                    wr_en_d    = !err_d;
                    idx_d      = '0;
                    cfg_addr_d = addr_q;
                    wdata_d    = pay_q[0];
                end
                default: ;
            endcase
        end else if (st_q == ST_COMMIT && wr_en_q && bus.cfg_ready) begin
            ok_d       = last;
            wr_en_d    = !last;
            st_d       = last ? ST_HUNT : ST_COMMIT;
            idx_d      = last ? idx_q : idx_q + 1'b1;
            cfg_addr_d = last ? cfg_addr_q : cfg_addr_q + 8'd1;
            wdata_d    = last ? wdata_q : pay_q[idx_q + 1'b1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= ST_HUNT;
            addr_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            csum_q     <= '0;
            wr_en_q    <= 1'b0;
            cfg_addr_q <= '0;
            wdata_q    <= '0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            tmo_q      <= '0;
            pay_q      <= '{default: '0};
        end else begin
            st_q       <= st_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            wr_en_q    <= wr_en_d;
            cfg_addr_q <= cfg_addr_d;
            wdata_q    <= wdata_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_q + byte_t'(err_d && err_cnt_q != 8'hFF);
            tmo_q      <= (!in_frame || rx_vld) ? '0 : tmo_q + 1'b1;
            if (rx_vld && st_q == ST_DATA) pay_q[idx_q] <= rx;
        end
    end

    assign bus.cfg_wr_en = wr_en_q;
    assign bus.cfg_addr  = cfg_addr_q;
    assign bus.cfg_wdata = wdata_q;
    assign frame_ok_o    = ok_q;
    assign frame_err_o   = err_q;
    assign err_cnt_o     = err_cnt_q;
    assign busy_o        = st_q != ST_HUNT;
endmodule

// File: tb/tb_dl_cmd_parser.sv
// tb_dl_cmd_parser: scoreboard bench; expected writes and frame events are queued when bytes are pushed
module tb_dl_cmd_parser;
    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_ok, frame_err, busy;
    logic [7:0] err_cnt;

    dl_cmd_parser_if bus();

    dl_cmd_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .frame_ok_o  (frame_ok),
        .frame_err_o (frame_err),
        .err_cnt_o   (err_cnt),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    logic [7:0]  fifo[$];
    logic [15:0] exp_wr[$];
    logic [1:0]  exp_ev[$];
    int n_chk = 0, n_err = 0, exp_errs = 0, stall = 0, rd_viol = 0;
    bit bp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // normal-mode FIFO: q updates the cycle after rdreq
    always @(posedge clk) begin
        if (bus.dl_fifo_rdreq && fifo.size() > 0) bus.dl_fifo_rddata <= fifo.pop_front();
        bus.dl_fifo_rdempty <= fifo.size() == 0;
    end

    always begin
        @(posedge clk);
        #1;
        if (!bp) bus.cfg_ready = 1'b1;
        else begin
            bus.cfg_ready = stall == 5;
            stall = bus.cfg_ready ? 0 : bus.cfg_wr_en ? stall + 1 : 0;
        end
    end

    always @(negedge clk) if (!rst) begin
        if (bus.cfg_wr_en && bus.cfg_ready) begin
            if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
            else chk("wr", {bus.cfg_addr, bus.cfg_wdata}, exp_wr.pop_front());
        end else if (bus.cfg_wr_en && exp_wr.size() > 0) begin
            chk("wr_hold", {bus.cfg_addr, bus.cfg_wdata}, exp_wr[0]);
        end
        if (frame_ok || frame_err) begin
            if (exp_ev.size() == 0) chk("ev_unexpected", {frame_ok, frame_err}, 0);
            else chk("ev", {frame_ok, frame_err}, exp_ev.pop_front());
        end
        if (bus.dl_fifo_rdreq && bus.cfg_wr_en) rd_viol++;
    end

    task automatic send(input logic [7:0] a, input logic [7:0] pl[$], input bit bad);
        logic [7:0] cs;
        cs = a ^ 8'(pl.size());
        fifo.push_back(8'hA5);
        fifo.push_back(8'h5A);
        fifo.push_back(a);
        fifo.push_back(8'(pl.size()));
        foreach (pl[i]) begin
            fifo.push_back(pl[i]);
            cs ^= pl[i];
        end
        fifo.push_back(bad ? cs ^ 8'h01 : cs);
        if (bad) begin
            exp_ev.push_back(2'b01);
            exp_errs++;
        end else begin
            foreach (pl[i]) exp_wr.push_back({a + 8'(i), pl[i]});
            exp_ev.push_back(2'b10);
        end
    endtask

    task automatic len_err(input logic [7:0] l);
        fifo.push_back(8'hA5);
        fifo.push_back(8'h5A);
        fifo.push_back(8'h40);
        fifo.push_back(l);
        exp_ev.push_back(2'b01);
        exp_errs++;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((fifo.size() != 0 || exp_wr.size() != 0 || exp_ev.size() != 0 || busy) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, n < 20000, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_errcnt"}, err_cnt, exp_errs > 255 ? 255 : exp_errs);
    endtask

    initial begin
        logic [7:0] pl[$];
        int n;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", bus.cfg_wr_en, 0);
        chk("rst_ok", frame_ok, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_errcnt", err_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdreq", bus.dl_fifo_rdreq, 0);
        rst = 1'b0;
        pl = {8'h11, 8'h22, 8'h33};
        send(8'h10, pl, 1'b0);
        drain("good");
        send(8'h10, pl, 1'b1);
        drain("bad_csum");
        send(8'h10, pl, 1'b0);
        drain("good2");
        fifo.push_back(8'h00);
        fifo.push_back(8'hA5);
        pl = {8'h7E};
        send(8'h20, pl, 1'b0);
        drain("resync");
        len_err(8'h00);
        drain("len0");
        len_err(8'(MAX_LEN + 1));
        drain("len_over");
        pl = {};
        for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'(i * 7 + 1));
        send(8'hF8, pl, 1'b0);
        drain("len_max");
        fifo.push_back(8'hA5);
        fifo.push_back(8'h5A);
        fifo.push_back(8'h30);
        fifo.push_back(8'h04);
        fifo.push_back(8'h01);
        exp_ev.push_back(2'b01);
        exp_errs++;
        n = 0;
        while (fifo.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!frame_err && n < TIMEOUT + 50) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_window", n >= TIMEOUT && n <= TIMEOUT + 3, 1);
        drain("tmo");
        repeat (300) len_err(8'h00);
        drain("saturate");
        bp = 1'b1;
        pl = {8'hAB, 8'hCD};
        send(8'hFF, pl, 1'b0);
        drain("bp_wrap");
        fifo.push_back(8'hA5);
        fifo.push_back(8'h5A);
        fifo.push_back(8'h50);
        fifo.push_back(8'h02);
        fifo.push_back(8'h01);
        fifo.push_back(8'h02);
        fifo.push_back(8'h51);
        n = 0;
        while (!bus.cfg_wr_en && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_commit_reached", bus.cfg_wr_en, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_wr_en", bus.cfg_wr_en, 0);
        chk("mid_rst_ok", frame_ok, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_errcnt", err_cnt, 0);
        rst = 1'b0;
        bp = 1'b0;
        exp_errs = 0;
        pl = {8'h5A, 8'hA5};
        send(8'h60, pl, 1'b0);
        drain("post_rst");
        chk("no_fetch_in_commit", rd_viol, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
